// File: rtl/button_debouncer.sv
// Pushbutton conditioner: synchronizes a raw pin, debounces it with a four-state FSM,
// and emits a clean level, press/release/long-press pulses and a press-toggled level.
module button_debouncer #(
    parameter int CNT_WIDTH   = 16,
    parameter int DB_CYCLES   = 50000,
    parameter int HOLD_WIDTH  = 24,
    parameter int LONG_CYCLES = 10000000,
    parameter int SYNC_STAGES = 2,
    parameter int ACTIVE_LOW  = 1
) (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic btn_i,
    output logic level_o,
    output logic press_o,
    output logic release_o,
    output logic long_o,
    output logic toggle_o
);

    typedef enum logic [1:0] {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} state_t;

    localparam logic                  IDLE_PIN  = (ACTIVE_LOW != 0);
    localparam logic [CNT_WIDTH-1:0]  CNT_ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0]  CNT_LAST  = CNT_WIDTH'(DB_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_ONE  = HOLD_WIDTH'(1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_LAST = HOLD_WIDTH'(LONG_CYCLES - 1);
    localparam logic [HOLD_WIDTH-1:0] HOLD_PRE  = HOLD_WIDTH'(LONG_CYCLES - 2);

    logic [SYNC_STAGES-1:0] sync;
    logic                   sp;
    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [HOLD_WIDTH-1:0]  hold;
    logic                   fired;

    // Chain resets to the released pin level so reset never looks like a press.
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) sync <= {SYNC_STAGES{IDLE_PIN}};
        else          sync <= {sync[SYNC_STAGES-2:0], btn_i};
    end

    assign sp = sync[SYNC_STAGES-1] ^ IDLE_PIN;

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state     <= IDLE;
            cnt       <= '0;
            hold      <= '0;
            fired     <= 1'b0;
            level_o   <= 1'b0;
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;
            toggle_o  <= 1'b0;
        end else begin
            press_o   <= 1'b0;
            release_o <= 1'b0;
            long_o    <= 1'b0;

            // Hold time keeps counting through release bounces; long fires when it lands on the last value.
            if ((state == PRESSED || state == RELEASE_WAIT) && hold != HOLD_LAST) begin
                hold <= hold + HOLD_ONE;
                if (hold == HOLD_PRE && !fired) begin
                    long_o <= 1'b1;
                    fired  <= 1'b1;
                end
            end

            case (state)
                IDLE: begin
                    if (sp) begin
                        state <= PRESS_WAIT;
                        cnt   <= CNT_ONE;
                    end else begin
                        cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!sp) begin
                        state <= IDLE;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state    <= PRESSED;
                        level_o  <= 1'b1;
                        press_o  <= 1'b1;
                        toggle_o <= ~toggle_o;
                        cnt      <= '0;
                        hold     <= '0;
                        fired    <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                PRESSED: begin
                    if (!sp) begin
                        state <= RELEASE_WAIT;
                        cnt   <= CNT_ONE;
                    end
                end
                RELEASE_WAIT: begin
                    if (sp) begin
                        state <= PRESSED;
                        cnt   <= '0;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        level_o   <= 1'b0;
                        release_o <= 1'b1;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Scoreboard bench for button_debouncer: an active-low and an active-high instance,
// expected pulse events queued with their cycle stamps and matched against observed pulses.
module tb_button_debouncer;

    logic clk = 1'b0, arstn = 1'b0, btn = 1'b1, btn_h = 1'b0;
    logic level, press, rel, lng, tog;
    logic level_h, press_h, rel_h, lng_h, tog_h;
    int   cyc = 0, checks = 0, errors = 0;
    logic exp_tog = 1'b0, exp_tog_h = 1'b0;

    // kind: 0 press, 1 release, 2 long (active-low unit); 3,4,5 same for active-high unit
    typedef struct {int kind; int cyc;} ev_t;
    ev_t expq[$], obsq[$];

    button_debouncer #(.DB_CYCLES(4), .LONG_CYCLES(16), .SYNC_STAGES(2), .ACTIVE_LOW(1)) dut (
        .clk_i(clk), .arstn_i(arstn), .btn_i(btn), .level_o(level), .press_o(press),
        .release_o(rel), .long_o(lng), .toggle_o(tog));

    button_debouncer #(.DB_CYCLES(4), .LONG_CYCLES(16), .SYNC_STAGES(2), .ACTIVE_LOW(0)) dut_h (
        .clk_i(clk), .arstn_i(arstn), .btn_i(btn_h), .level_o(level_h), .press_o(press_h),
        .release_o(rel_h), .long_o(lng_h), .toggle_o(tog_h));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (press)   obsq.push_back('{0, cyc});
        if (rel)     obsq.push_back('{1, cyc});
        if (lng)     obsq.push_back('{2, cyc});
        if (press_h) obsq.push_back('{3, cyc});
        if (rel_h)   obsq.push_back('{4, cyc});
        if (lng_h)   obsq.push_back('{5, cyc});
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        ev_t e, o;
        step(3);
        checks++;
        if ({level, press, rel, lng, tog} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs: got %b, expected 00000", {level, press, rel, lng, tog});
        end
        checks++;
        if ({level_h, press_h, rel_h, lng_h, tog_h} !== 5'b0) begin
            errors++; $display("FAIL reset_outputs_h: got %b, expected 00000", {level_h, press_h, rel_h, lng_h, tog_h});
        end
        arstn = 1'b1;
        step(8);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL reset_idle_level: got %b, expected 0", level); end
        #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL reset_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL reset_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL reset_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_clean_press;
        ev_t e, o;
        int c;
        c = cyc; btn = 1'b0;
        expq.push_back('{0, c + 6}); exp_tog = ~exp_tog;
        step(5);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL clean_press_early: level %b, expected 0", level); end
        step(1);
        checks++;
        if (level !== 1'b1 || tog !== exp_tog) begin
            errors++; $display("FAIL clean_press_level: level %b toggle %b, expected 1 %b", level, tog, exp_tog);
        end
        step(3); #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL clean_press_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL clean_press_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL clean_press_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_release;
        ev_t e, o;
        int c;
        c = cyc; btn = 1'b1;
        expq.push_back('{1, c + 6});
        step(5);
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL release_early: level %b, expected 1", level); end
        step(1);
        checks++;
        if (level !== 1'b0 || tog !== exp_tog) begin
            errors++; $display("FAIL release_level: level %b toggle %b, expected 0 %b", level, tog, exp_tog);
        end
        step(3); #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL release_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL release_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL release_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_bounce;
        ev_t e, o;
        int c;
        c = cyc; btn = 1'b0;
        step(3); btn = 1'b1;
        step(1); btn = 1'b0;
        expq.push_back('{0, c + 10}); exp_tog = ~exp_tog;
        step(5);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL bounce_early: level %b, expected 0", level); end
        step(1);
        checks++;
        if (level !== 1'b1 || tog !== exp_tog) begin
            errors++; $display("FAIL bounce_level: level %b toggle %b, expected 1 %b", level, tog, exp_tog);
        end
        step(3); #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL bounce_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL bounce_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL bounce_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_release_glitch;
        ev_t e, o;
        int c;
        c = cyc; btn = 1'b1;
        step(2); btn = 1'b0;
        step(1); btn = 1'b1;
        expq.push_back('{1, c + 9});
        step(5);
        checks++;
        if (level !== 1'b1) begin errors++; $display("FAIL glitch_hold: level %b, expected 1", level); end
        step(1);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL glitch_level: level %b, expected 0", level); end
        step(3); #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL glitch_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL glitch_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL glitch_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_long_press;
        ev_t e, o;
        int c;
        // held 20 cycles past the press: one long pulse at P+15
        c = cyc; btn = 1'b0;
        expq.push_back('{0, c + 6}); expq.push_back('{2, c + 21}); exp_tog = ~exp_tog;
        step(26); btn = 1'b1;
        expq.push_back('{1, c + 32});
        step(9);
        // release accepted at P+10: no long pulse
        c = cyc; btn = 1'b0;
        expq.push_back('{0, c + 6}); exp_tog = ~exp_tog;
        step(10); btn = 1'b1;
        expq.push_back('{1, c + 16});
        step(16);
        checks++;
        if (level !== 1'b0 || tog !== exp_tog) begin
            errors++; $display("FAIL long_final: level %b toggle %b, expected 0 %b", level, tog, exp_tog);
        end
        #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL long_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL long_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL long_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_reset_mid;
        ev_t e, o;
        int r;
        btn = 1'b0;
        step(3);
        arstn = 1'b0; exp_tog = 1'b0; #1;
        checks++;
        if ({level, press, rel, lng, tog} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_wait: got %b, expected 00000", {level, press, rel, lng, tog});
        end
        step(2); arstn = 1'b1; r = cyc;
        expq.push_back('{0, r + 6}); exp_tog = 1'b1;
        step(5);
        checks++;
        if (level !== 1'b0) begin errors++; $display("FAIL reset_mid_repress_early: level %b, expected 0", level); end
        step(1);
        checks++;
        if (level !== 1'b1 || press !== 1'b1 || tog !== exp_tog) begin
            errors++; $display("FAIL reset_mid_repress: level %b press %b toggle %b, expected 1 1 %b", level, press, tog, exp_tog);
        end
        #1; arstn = 1'b0; exp_tog = 1'b0; #1;
        checks++;
        if ({level, press, rel, lng, tog} !== 5'b0) begin
            errors++; $display("FAIL reset_mid_pressed: got %b, expected 00000", {level, press, rel, lng, tog});
        end
        step(2); arstn = 1'b1; r = cyc;
        expq.push_back('{0, r + 6}); exp_tog = 1'b1;
        step(6);
        checks++;
        if (level !== 1'b1 || tog !== exp_tog) begin
            errors++; $display("FAIL reset_mid_fresh_press: level %b toggle %b, expected 1 %b", level, tog, exp_tog);
        end
        step(2); btn = 1'b1;
        expq.push_back('{1, cyc + 6});
        step(9); #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL reset_mid_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL reset_mid_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL reset_mid_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    task automatic test_active_high;
        ev_t e, o;
        int c, r;
        c = cyc; btn_h = 1'b1;
        expq.push_back('{3, c + 6}); exp_tog_h = 1'b1;
        step(5);
        checks++;
        if (level_h !== 1'b0) begin errors++; $display("FAIL high_press_early: level %b, expected 0", level_h); end
        step(1);
        checks++;
        if (level_h !== 1'b1 || tog_h !== exp_tog_h) begin
            errors++; $display("FAIL high_press: level %b toggle %b, expected 1 %b", level_h, tog_h, exp_tog_h);
        end
        step(2); btn_h = 1'b0;
        expq.push_back('{4, cyc + 6});
        step(9);
        // pin idling at the pressed level through reset
        arstn = 1'b0; btn_h = 1'b1; exp_tog_h = 1'b0; exp_tog = 1'b0; #1;
        checks++;
        if ({level_h, press_h, rel_h, lng_h, tog_h} !== 5'b0) begin
            errors++; $display("FAIL high_reset: got %b, expected 00000", {level_h, press_h, rel_h, lng_h, tog_h});
        end
        step(2); arstn = 1'b1; r = cyc;
        expq.push_back('{3, r + 6}); exp_tog_h = 1'b1;
        step(6);
        checks++;
        if (level_h !== 1'b1 || tog_h !== exp_tog_h) begin
            errors++; $display("FAIL high_held_reset_press: level %b toggle %b, expected 1 %b", level_h, tog_h, exp_tog_h);
        end
        step(2); btn_h = 1'b0;
        expq.push_back('{4, cyc + 6});
        step(9);
        // pin idling released through reset
        arstn = 1'b0;
        step(2); arstn = 1'b1;
        step(20);
        checks++;
        if (level_h !== 1'b0 || tog_h !== 1'b0) begin
            errors++; $display("FAIL high_idle_reset: level %b toggle %b, expected 0 0", level_h, tog_h);
        end
        #1;
        while (expq.size() > 0) begin
            e = expq.pop_front(); checks++;
            if (obsq.size() == 0) begin errors++; $display("FAIL high_event: got none, expected kind %0d at %0d", e.kind, e.cyc); end
            else begin
                o = obsq.pop_front();
                if (o.kind !== e.kind || o.cyc !== e.cyc) begin
                    errors++; $display("FAIL high_event: got kind %0d at %0d, expected kind %0d at %0d", o.kind, o.cyc, e.kind, e.cyc);
                end
            end
        end
        checks++;
        if (obsq.size() != 0) begin errors++; $display("FAIL high_extra: got %0d extra events, expected 0", obsq.size()); obsq.delete(); end
    endtask

    initial begin
        test_reset;
        test_clean_press;
        test_release;
        test_bounce;
        test_release_glitch;
        test_long_press;
        test_reset_mid;
        test_active_high;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
